adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one combinational 5-bit adder (6-bit sum, no carry-in) between NREQ requesters.
//  Round-robin arbitration; one transaction in flight at a time.
//  The block drives the adder operands, holds them SETTLE_CYCLES, captures the sum and returns it.
//  The returned sum carries the requester ID.
//  Sits between client blocks and the single adder instance, which is external and wired to add_a/add_b/add_q.
// PARAMETERS
//  NREQ          4   number of requesters, 2..8
//  IDW           2   requester-ID width, $clog2(NREQ)
//  SETTLE_CYCLES 1   cycles the operands are held on add_a/add_b before add_q is sampled, 1..15
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        reset, asynchronous, active-low
//  req_valid   in   NREQ     request i valid
//  req_ready   out  NREQ     request i accepted this cycle, one-hot or zero
//  req_a       in   NREQ*5   operand a of requester i, bits [5i+4:5i]
//  req_b       in   NREQ*5   operand b of requester i, bits [5i+4:5i]
//  resp_valid  out  1        result available
//  resp_ready  in   1        consumer takes result
//  resp_id     out  IDW      requester index of the result
//  resp_sum    out  6        a + b, zero-extended, no overflow possible
//  add_a       out  5        operand a to the shared adder
//  add_b       out  5        operand b to the shared adder
//  add_q       in   6        sum from the shared adder
//  busy        out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs are 0; state=IDLE; rr pointer=0; settle counter=0.
//   - An in-flight transaction is dropped silently, with no response.
//  IDLE
//   - If any req_valid: pick the first valid index searching ptr, ptr+1, .. mod NREQ.
//   - Assert req_ready[win] combinationally in the same cycle.
//   - Latch a, b and id=win; go to ISSUE. ptr <= (win+1) mod NREQ.
//   - No valid request: stay in IDLE; req_ready=0.
//  ISSUE
//   - add_a/add_b driven from the latched operands; they are 0 in every other state.
//   - Counter runs 0..SETTLE_CYCLES-1. On the last count: result <= add_q; go to RESP.
//  RESP
//   - resp_valid=1; resp_id and resp_sum are stable until the handshake.
//   - resp_valid && resp_ready: handshake completes; go to IDLE the next cycle.
//   - No new grant is made in the handshake cycle.
//  Timing and throughput
//   - Latency: grant in cycle 0; resp_valid first high in cycle 1+SETTLE_CYCLES.
//   - Minimum spacing between grants is SETTLE_CYCLES+2 cycles.
//  Rules
//   - req_ready is never high outside IDLE. At most one bit is set.
//   - Requests are not queued. A requester keeps req_valid high until it sees req_ready.
//   - Dropping req_valid before the grant is legal and causes no side effects.
//   - Operand changes on req_a/req_b after the grant do not affect the captured result.
//   - A requester whose req_valid is held waits at most NREQ-1 other transactions (starvation-free).
//   - add_q is sampled only on the last ISSUE cycle, so glitches on add_q in other cycles are ignored.
// TESTING
//  1. Single request, NREQ=4, SETTLE=1: req 2 sends a=31, b=31.
//     -> req_ready[2] in cycle 0; add_a=31 in cycle 1; resp_valid in cycle 2 with id=2, sum=62.
//  2. All four requesters valid every cycle, resp_ready=1.
//     -> grant order 0,1,2,3,0; each resp_sum equals that requester's a+b.
//  3. Backpressure: resp_ready=0 for 5 cycles on a=7, b=9.
//     -> resp_valid and sum=16 held stable; req_ready stays 0; one grant after the handshake.
//  4. SETTLE=3 with a=1, b=1: add_q forced to 63 for the first 2 ISSUE cycles.
//     -> resp_sum=2 (the last cycle's add_q); resp_valid in cycle 4.
//  5. rst_n low mid-ISSUE, then released.
//     -> all outputs 0 asynchronously; no response is produced; the next grant restarts at ptr=0.
//  6. Exhaustive: every a,b in 0..31 on requester 0 through a behavioural adder.
//     -> every resp_sum equals a+b.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin front end that time-shares one external 5-bit adder across NREQ requesters.
// Latency: grant in cycle 0, resp_valid from cycle 1+SETTLE_CYCLES; resp_ready low holds the result and blocks new grants.
module adder_share_arbiter #(
   parameter int NREQ          = 4,
   parameter int IDW           = $clog2(NREQ),
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*5-1:0] req_a,
   input  logic [NREQ*5-1:0] req_b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [IDW-1:0]    resp_id,
   output logic [5:0]        resp_sum,
   output logic [4:0]        add_a,
   output logic [4:0]        add_b,
   input  logic [5:0]        add_q,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic           win_vld;
   logic           grant;
   logic [IDW-1:0] id_q;
   logic [4:0]     a_q;
   logic [4:0]     b_q;
   logic [5:0]     sum_q;
   logic [3:0]     cnt;
   logic           last_cnt;
   logic [4:0]     op_a [NREQ];
   logic [4:0]     op_b [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_ops
      assign op_a[i] = req_a[i*5 +: 5];
      assign op_b[i] = req_b[i*5 +: 5];
   end

   // First valid requester at or after ptr, wrapping once around.
   always_comb begin
      int idx;
      win_vld = 1'b0;
      win     = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!win_vld && req_valid[IDW'(idx)]) begin
            win_vld = 1'b1;
            win     = IDW'(idx);
         end
      end
   end

   // rst_n gates the combinational grant so req_ready is 0 throughout reset.
   assign grant    = (state == IDLE) && win_vld && rst_n;
   assign last_cnt = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld)    state_nxt = ISSUE;
         ISSUE:   if (last_cnt)   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      add_a      = '0;
      add_b      = '0;
      resp_valid = 1'b0;
      resp_id    = '0;
      resp_sum   = '0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               req_ready[win] = 1'b1;
            end
         end
         ISSUE: begin
            add_a = a_q;
            add_b = b_q;
            busy  = 1'b1;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_id    = id_q;
            resp_sum   = sum_q;
            busy       = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Operands are latched at grant so later req_a/req_b changes cannot leak into the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         id_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
         cnt   <= '0;
      end else begin
         if (state == IDLE && win_vld) begin
            id_q <= win;
            a_q  <= op_a[win];
            b_q  <= op_b[win];
            if (int'(win) == NREQ - 1) begin
               ptr <= '0;
            end else begin
               ptr <= win + 1'b1;
            end
         end
         if (state == ISSUE) begin
            if (last_cnt) begin
               cnt   <= '0;
               sum_q <= add_q;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

   a_ready_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
      (state != IDLE) |-> (req_ready == '0));

   a_resp_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_id) && $stable(resp_sum)));

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts grants, adder drive and responses.
module tb_adder_share_arbiter;
   localparam int N   = 4;
   localparam int S   = 3;
   localparam int IDW = 2;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*5-1:0]   req_a;
   logic [N*5-1:0]   req_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [IDW-1:0]   resp_id;
   logic [5:0]       resp_sum;
   logic [4:0]       add_a;
   logic [4:0]       add_b;
   logic [5:0]       add_q;
   logic             busy;

   adder_share_arbiter #(.NREQ(N), .IDW(IDW), .SETTLE_CYCLES(S)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_q      (add_q),
      .busy       (busy)
   );

   typedef struct {
      int     id;
      int     a;
      int     b;
      longint gcyc;
   } exp_t;

   exp_t     sbq[$];
   int       checks  = 0;
   int       errors  = 0;
   longint   cyc     = 0;
   bit       free_m  = 1'b1;
   int       ptr_m   = 0;
   bit       hs_pend = 1'b0;
   bit [N-1:0] granted = '0;
   bit       glitch63 = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input bit v, input int a, input int b);
      req_valid[i]     = v;
      req_a[i*5 +: 5]  = 5'(a);
      req_b[i*5 +: 5]  = 5'(b);
   endtask

   // Model: one transaction at a time, round-robin from the last winner + 1.
   task automatic model_check();
      logic [N-1:0] exp_rdy;
      int win;
      int idx;
      exp_rdy = '0;
      win     = -1;
      chk("busy", busy, !free_m);
      if (free_m) begin
         for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (win < 0 && req_valid[idx]) win = idx;
         end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (win >= 0) begin
         sbq.push_back('{win, int'(req_a[win*5 +: 5]), int'(req_b[win*5 +: 5]), cyc});
         ptr_m        = (win + 1) % N;
         free_m       = 1'b0;
         granted[win] = 1'b1;
      end
   endtask

   task automatic tick();
      #3;
      if (rst_n) model_check();
      @(negedge clk);
   endtask

   task automatic drop_granted();
      for (int i = 0; i < N; i++) begin
         if (granted[i]) begin
            granted[i] = 1'b0;
            set_req(i, 1'b0, $urandom_range(31), $urandom_range(31));
         end
      end
   endtask

   task automatic rand_cycles(input int n, input int p_new, input int p_ready, input int p_drop);
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
               granted[i] = 1'b0;
               set_req(i, 1'b0, $urandom_range(31), $urandom_range(31));
            end else if (req_valid[i] && int'($urandom_range(99)) < p_drop) begin
               req_valid[i] = 1'b0;
            end else if (!req_valid[i] && int'($urandom_range(99)) < p_new) begin
               set_req(i, 1'b1, $urandom_range(31), $urandom_range(31));
            end
         end
         resp_ready = int'($urandom_range(99)) < p_ready;
         tick();
      end
   endtask

   task automatic drain();
      drop_granted();
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (S + 4) tick();
      chk("drain_empty", sbq.size(), 0);
   endtask

   // External adder: correct only on the sampling cycle, garbage elsewhere.
   initial begin
      add_q = '0;
      forever begin
         @(negedge clk);
         #1;
         if (sbq.size() > 0 && cyc == sbq[0].gcyc + S)
            add_q = 6'(add_a) + 6'(add_b);
         else
            add_q = glitch63 ? 6'd63 : 6'($urandom_range(63));
      end
   end

   // Monitor: compares adder drive and responses against the oldest outstanding grant.
   initial begin
      exp_t e;
      bit   exp_v;
      bit   iss;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            exp_v = 1'b0;
            iss   = 1'b0;
            e     = '{0, 0, 0, 0};
            if (sbq.size() > 0) begin
               e     = sbq[0];
               exp_v = (cyc >= e.gcyc + 1 + S);
               iss   = (cyc > e.gcyc) && (cyc <= e.gcyc + S);
            end
            chk("resp_valid", resp_valid, exp_v);
            chk("add_a", add_a, iss ? e.a : 0);
            chk("add_b", add_b, iss ? e.b : 0);
            if (exp_v) begin
               chk("resp_id", resp_id, e.id);
               chk("resp_sum", resp_sum, e.a + e.b);
               if (resp_ready) begin
                  void'(sbq.pop_front());
                  hs_pend = 1'b1;
               end
            end
         end
         if (hs_pend) begin
            @(posedge clk);
            free_m  = 1'b1;
            hs_pend = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int n;
      rst_n      = 1'b0;
      req_valid  = '1;
      req_a      = '1;
      req_b      = '1;
      resp_ready = 1'b1;
      #2;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_sum", resp_sum, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_busy", busy, 0);
      req_valid = '0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Single request, maximum operands.
      set_req(2, 1'b1, 31, 31);
      tick();
      drop_granted();
      repeat (S + 3) tick();

      // Backpressure with other requesters waiting.
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 7, 9);
      resp_ready = 1'b0;
      repeat (S + 6) begin
         tick();
         drop_granted();
      end
      resp_ready = 1'b1;
      repeat (S + 4) begin
         tick();
         drop_granted();
      end
      drain();

      // add_q forced to 63 outside the sampling cycle.
      glitch63 = 1'b1;
      set_req(1, 1'b1, 1, 1);
      tick();
      drop_granted();
      repeat (S + 3) tick();
      glitch63 = 1'b0;

      // Reset during ISSUE drops the transaction and resets the pointer.
      set_req(3, 1'b1, 5, 6);
      tick();
      drop_granted();
      tick();
      req_valid = '1;
      #1 rst_n = 1'b0;
      sbq.delete();
      free_m  = 1'b1;
      ptr_m   = 0;
      hs_pend = 1'b0;
      #1;
      chk("arst_req_ready", req_ready, 0);
      chk("arst_add_a", add_a, 0);
      chk("arst_add_b", add_b, 0);
      chk("arst_resp_valid", resp_valid, 0);
      chk("arst_busy", busy, 0);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // All requesters continuously valid: order 0,1,2,3,0.
      rand_cycles(5 * (S + 2), 100, 100, 0);
      drain();

      // Random traffic with drops and backpressure.
      rand_cycles(3000, 30, 70, 5);
      drain();

      // Exhaustive operand sweep on requester 0.
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            drop_granted();
            set_req(0, 1'b1, a, b);
            n = 0;
            do begin
               tick();
               n++;
            end while (!granted[0] && n < 2 * (S + 2));
            chk("sweep_grant", granted[0], 1);
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
